// File: rtl/canny_window_feeder.sv
// -----------------------------------------------------------------------------
// canny_window_feeder
//
// Front end of the CannyEdge detector. It takes a raster-order 8-bit pixel
// stream and keeps the last four image lines in line buffers. From these it
// builds a 5x5 sliding window. For every complete window it does four things:
//   1. writes all 25 window pixels into the detector's regX over the bus,
//   2. runs MODE_GAUSSIAN,
//   3. reads Out_gf back,
//   4. presents the smoothed pixel on a valid/ready result port.
//
// Ports
//   clk, rst_b             clock (posedge) and asynchronous active-low reset
//   pix_valid/pix_data     input pixel stream, row 0 col 0 first
//   pix_ready              feeder accepts a pixel this cycle
//   res_valid/res_ready    result handshake (res_* held while waiting)
//   res_data               smoothed pixel read back from the detector
//   res_row/res_col        window centre coordinates (row-2, col-2)
//   det_row/det_col        detector register address (dAddrRegRow/Col)
//   det_bWE/det_bCE        detector bus write enable / chip enable, active low
//   det_wreg/det_rreg      detector register selects, fixed to 0
//   det_opmode             detector operation mode, fixed to MODE_GAUSSIAN
//   det_bOPEn              detector operation enable, active low
//   det_data/det_out       detector write data / read data
// -----------------------------------------------------------------------------
module canny_window_feeder #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int COL_W      = 6,
    parameter int ROW_W      = 6,
    parameter int OP_CYCLES  = 3
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             pix_valid,
    input  logic [7:0]       pix_data,
    output logic             pix_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_data,
    output logic [ROW_W-1:0] res_row,
    output logic [COL_W-1:0] res_col,
    output logic [2:0]       det_row,
    output logic [2:0]       det_col,
    output logic             det_bWE,
    output logic             det_bCE,
    output logic [3:0]       det_wreg,
    output logic [3:0]       det_rreg,
    output logic [2:0]       det_opmode,
    output logic             det_bOPEn,
    output logic [7:0]       det_data,
    input  logic [7:0]       det_out
);

    localparam int OPC_W = $clog2(OP_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_OP   = 3'd2,
        S_CLR  = 3'd3,
        S_READ = 3'd4,
        S_CAPT = 3'd5,
        S_OUT  = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [OPC_W-1:0]   op_cnt_q, op_cnt_d;
    logic [7:0]         win_q [0:4][0:4];
    logic [7:0]         win_d [0:4][0:4];
    logic [7:0]         lb_q  [0:3][0:IMG_WIDTH-1];
    logic [7:0]         lb_rd_s [0:3];
    logic               accept_s;

    logic               pix_ready_q, pix_ready_d;
    logic               res_valid_q, res_valid_d;
    logic [7:0]         res_data_q, res_data_d;
    logic [ROW_W-1:0]   res_row_q, res_row_d;
    logic [COL_W-1:0]   res_col_q, res_col_d;
    logic [2:0]         det_row_q, det_row_d;
    logic [2:0]         det_col_q, det_col_d;
    logic               det_bwe_q, det_bwe_d;
    logic               det_bce_q, det_bce_d;
    logic               det_bopen_q, det_bopen_d;
    logic [7:0]         det_data_q, det_data_d;

    // Line-buffer read port: all four lines at the current column.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lb_rd_s[k] = lb_q[k][col_q];
        end
    end

    // Next-state, counters, window shift and result capture.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        op_cnt_d   = op_cnt_q;
        win_d      = win_q;
        res_row_d  = res_row_q;
        res_col_d  = res_col_q;
        res_data_d = res_data_q;
        det_row_d  = 3'd0;
        det_col_d  = 3'd0;
        // pix_ready_q is low for the first cycle after reset even in IDLE.
        accept_s   = pix_ready_q & pix_valid & (state_q == S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    for (int r = 0; r < 5; r++) begin
                        for (int c = 0; c < 4; c++) begin
                            win_d[r][c] = win_q[r][c+1];
                        end
                    end
                    // Newest column: oldest line at window row 0.
                    win_d[0][4] = lb_rd_s[3];
                    win_d[1][4] = lb_rd_s[2];
                    win_d[2][4] = lb_rd_s[1];
                    win_d[3][4] = lb_rd_s[0];
                    win_d[4][4] = pix_data;

                    if (col_q == COL_W'(IMG_WIDTH - 1)) begin
                        col_d = {COL_W{1'b0}};
                        if (row_q == ROW_W'(IMG_HEIGHT - 1)) begin
                            row_d = {ROW_W{1'b0}};
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end

                    // Decided on pre-increment position, so a window never
                    // straddles a row or frame wrap.
                    if ((row_q >= ROW_W'(4)) && (col_q >= COL_W'(4))) begin
                        res_row_d = row_q - ROW_W'(2);
                        res_col_d = col_q - COL_W'(2);
                        state_d   = S_LOAD;
                    end else begin
                        state_d   = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                // det_row/det_col are the write index (k/5, k%5).
                if (det_col_q == 3'd4) begin
                    if (det_row_q == 3'd4) begin
                        state_d  = S_OP;
                        op_cnt_d = {OPC_W{1'b0}};
                    end else begin
                        det_row_d = det_row_q + 3'd1;
                        det_col_d = 3'd0;
                    end
                end else begin
                    det_row_d = det_row_q;
                    det_col_d = det_col_q + 3'd1;
                end
            end
            S_OP: begin
                if (op_cnt_q == OPC_W'(OP_CYCLES - 1)) begin
                    state_d = S_CLR;
                end else begin
                    op_cnt_d = op_cnt_q + OPC_W'(1);
                end
            end
            S_CLR:  state_d = S_READ;
            S_READ: state_d = S_CAPT;
            S_CAPT: begin
                // OutData was registered by the detector at the end of READ.
                res_data_d = det_out;
                state_d    = S_OUT;
            end
            S_OUT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so all outputs leave flops.
    always_comb begin
        pix_ready_d = 1'b0;
        res_valid_d = 1'b0;
        det_bce_d   = 1'b1;
        det_bwe_d   = 1'b1;
        det_bopen_d = 1'b1;
        det_data_d  = 8'd0;
        case (state_d)
            S_IDLE: pix_ready_d = 1'b1;
            S_LOAD: begin
                det_bce_d  = 1'b0;
                det_bwe_d  = 1'b0;
                det_data_d = win_d[det_row_d][det_col_d];
            end
            S_OP:   det_bopen_d = 1'b0;
            S_READ: det_bce_d   = 1'b0;
            S_OUT:  res_valid_d = 1'b1;
            S_CLR, S_CAPT: det_bce_d = 1'b1;
            default: pix_ready_d = 1'b0;
        endcase
    end

    // Control, window and output registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= S_IDLE;
            col_q       <= {COL_W{1'b0}};
            row_q       <= {ROW_W{1'b0}};
            op_cnt_q    <= {OPC_W{1'b0}};
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    win_q[r][c] <= 8'd0;
                end
            end
            pix_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'd0;
            res_row_q   <= {ROW_W{1'b0}};
            res_col_q   <= {COL_W{1'b0}};
            det_row_q   <= 3'd0;
            det_col_q   <= 3'd0;
            det_bwe_q   <= 1'b1;
            det_bce_q   <= 1'b1;
            det_bopen_q <= 1'b1;
            det_data_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            op_cnt_q    <= op_cnt_d;
            win_q       <= win_d;
            pix_ready_q <= pix_ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_row_q   <= res_row_d;
            res_col_q   <= res_col_d;
            det_row_q   <= det_row_d;
            det_col_q   <= det_col_d;
            det_bwe_q   <= det_bwe_d;
            det_bce_q   <= det_bce_d;
            det_bopen_q <= det_bopen_d;
            det_data_q  <= det_data_d;
        end
    end

    // Line-buffer RAM (not reset): each line moves one buffer down.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb_q[0][col_q] <= pix_data;
            for (int k = 1; k < 4; k++) begin
                lb_q[k][col_q] <= lb_rd_s[k-1];
            end
        end
    end

    assign pix_ready  = pix_ready_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_row    = res_row_q;
    assign res_col    = res_col_q;
    assign det_row    = det_row_q;
    assign det_col    = det_col_q;
    assign det_bWE    = det_bwe_q;
    assign det_bCE    = det_bce_q;
    assign det_bOPEn  = det_bopen_q;
    assign det_data   = det_data_q;
    assign det_wreg   = 4'd0;
    assign det_rreg   = 4'd0;
    assign det_opmode = 3'd0;

endmodule

// File: tb/tb_canny_window_feeder.sv
// Bench for canny_window_feeder on an 8x6 image. It contains three parts:
//   - A simple detector model answering the bus: regX writes, a Gaussian run
//     (weights 2*a[i]*a[j], a = 1,2,2,2,1, sum 128) and an OutData read.
//   - A frame-level reference model that computes every window result from
//     the pixel history.
//   - One negedge compare process.
module tb_canny_window_feeder;

    localparam int W   = 8;
    localparam int H   = 6;
    localparam int OPC = 3;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       pix_ready;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [2:0] res_row;
    logic [2:0] res_col;
    logic [2:0] det_row;
    logic [2:0] det_col;
    logic       det_bWE;
    logic       det_bCE;
    logic [3:0] det_wreg;
    logic [3:0] det_rreg;
    logic [2:0] det_opmode;
    logic       det_bOPEn;
    logic [7:0] det_data;
    logic [7:0] det_out;

    canny_window_feeder #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_W(3), .ROW_W(3), .OP_CYCLES(OPC)
    ) dut (
        .clk(clk), .rst_b(rst_b),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_row(res_row), .res_col(res_col),
        .det_row(det_row), .det_col(det_col), .det_bWE(det_bWE), .det_bCE(det_bCE),
        .det_wreg(det_wreg), .det_rreg(det_rreg), .det_opmode(det_opmode),
        .det_bOPEn(det_bOPEn), .det_data(det_data), .det_out(det_out)
    );

    always #5 clk = ~clk;

    typedef struct { int d; int r; int c; } res_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   rr_mode = 0;
    res_t rq[$];
    res_t got[$];
    int   wq[$];
    int   img [0:H-1][0:W-1];
    int   m_row = 0, m_col = 0, wr_k = 0, op_cnt = 0, win_cyc = 0, s = 0;
    bit   prev_valid = 1'b0;
    logic [7:0] regx [0:4][0:4];
    int   gf_m = 0;

    function automatic int wgt(input int i, input int j);
        int ai, aj;
        ai = (i == 0 || i == 4) ? 1 : 2;
        aj = (j == 0 || j == 4) ? 1 : 2;
        return 2 * ai * aj;
    endfunction

    function automatic int gauss_regx();
        int acc = 0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                acc += wgt(i, j) * int'(regx[i][j]);
        return acc >> 7;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Detector model: regX writes, Gaussian while bOPEnable low, OutData on read.
    always @(posedge clk) begin
        if (!det_bCE && !det_bWE) regx[det_row][det_col] <= det_data;
        if (!det_bOPEn) gf_m <= gauss_regx();
        if (!det_bCE && det_bWE) det_out <= 8'(gf_m);
    end

    // Compare process: reference model plus per-cycle output checks.
    always @(negedge clk) begin
        cyc++;
        if (!rst_b) begin
            rq.delete(); wq.delete();
            m_row = 0; m_col = 0; wr_k = 0; op_cnt = 0; prev_valid = 1'b0;
        end else begin
            if (!det_bCE && !det_bWE) begin
                chk("bus_write_expected", int'(wq.size() > 0), 1);
                if (wq.size() > 0) begin
                    chk("bus_wdata", det_data, wq.pop_front());
                    chk("bus_wrow", det_row, wr_k / 5);
                    chk("bus_wcol", det_col, wr_k % 5);
                end
                chk("load_pix_ready", pix_ready, 0);
                wr_k++;
            end
            if (!det_bOPEn) begin
                chk("op_bus_idle", det_bCE, 1);
                op_cnt++;
            end
            if (!det_bCE && det_bWE) begin
                chk("read_after_25_writes", wr_k, 25);
                chk("op_cycles", op_cnt, OPC);
                wr_k = 0; op_cnt = 0;
            end
            if (res_valid) begin
                chk("result_expected", int'(rq.size() > 0), 1);
                if (rq.size() > 0) begin
                    if (!prev_valid) chk("latency", cyc - win_cyc, 29 + OPC);
                    chk("res_data", res_data, rq[0].d);
                    chk("res_row", res_row, rq[0].r);
                    chk("res_col", res_col, rq[0].c);
                    chk("out_pix_ready", pix_ready, 0);
                    if (res_ready) begin
                        got.push_back('{int'(res_data), int'(res_row), int'(res_col)});
                        void'(rq.pop_front());
                    end
                end
            end
            prev_valid = res_valid && !res_ready;
            if (pix_valid && pix_ready) begin
                img[m_row][m_col] = int'(pix_data);
                if (m_row >= 4 && m_col >= 4) begin
                    s = 0;
                    for (int i = 0; i < 5; i++)
                        for (int j = 0; j < 5; j++) begin
                            s += wgt(i, j) * img[m_row-4+i][m_col-4+j];
                            wq.push_back(img[m_row-4+i][m_col-4+j]);
                        end
                    rq.push_back('{s >> 7, m_row - 2, m_col - 2});
                    win_cyc = cyc;
                end
                if (m_col == W - 1) begin
                    m_col = 0;
                    m_row = (m_row == H - 1) ? 0 : m_row + 1;
                end else begin
                    m_col++;
                end
            end
        end
    end

    // res_ready driver: 0 = always high, 1 = random, 2 = held low.
    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rr_mode)
                0: res_ready = 1'b1;
                1: res_ready = 1'($urandom_range(0, 1));
                default: res_ready = 1'b0;
            endcase
        end
    end

    task automatic send_pix(input int v, input int gap);
        bit acc = 1'b0;
        int t = 0;
        if (gap > 0 && $urandom_range(0, 99) < gap) begin
            pix_valid = 1'b0;
            @(posedge clk); #1;
        end
        pix_valid = 1'b1;
        pix_data  = 8'(v);
        while (!acc && t < 400) begin
            @(negedge clk);
            acc = pix_ready;
            @(posedge clk); #1;
            t++;
        end
        chk("pix_accept_timeout", int'(acc), 1);
    endtask

    // mode 0 = constant v, 1 = row*8+col, 2 = random
    task automatic send_range(input int mode, input int v, input int first, input int last, input int gap);
        int p;
        for (int i = first; i <= last; i++) begin
            p = (mode == 0) ? v : (mode == 1) ? i : int'($urandom_range(0, 255));
            send_pix(p, gap);
        end
        pix_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((rq.size() != 0 || res_valid) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_timeout", int'(t < 3000), 1);
    endtask

    initial begin
        rst_b = 1'b0; pix_valid = 1'b0; pix_data = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_row", res_row, 0);
        chk("rst_res_col", res_col, 0);
        chk("rst_bCE", det_bCE, 1);
        chk("rst_bWE", det_bWE, 1);
        chk("rst_bOPEn", det_bOPEn, 1);
        chk("rst_det_rc", {det_row, det_col}, 0);
        chk("rst_det_data", det_data, 0);
        chk("const_regs", {det_wreg, det_rreg, det_opmode}, 0);
        @(posedge clk); #1 rst_b = 1'b1;

        // All-128 frame: every window smooths to 128.
        got.delete();
        send_range(0, 128, 0, W*H-1, 0);
        drain();
        chk("c128_count", got.size(), 8);
        if (got.size() == 8) begin
            chk("c128_data", got[0].d, 128);
            chk("c128_rc", got[0].r * 8 + got[0].c, 2 * 8 + 2);
        end

        // Ramp, pix_valid held high: results equal the centre pixel.
        got.delete();
        send_range(1, 0, 0, W*H-1, 0);
        drain();
        chk("ramp_count", got.size(), 8);
        if (got.size() == 8) begin
            chk("ramp_first", got[0].d, 18);
            chk("ramp_last", got[7].d, 29);
            chk("ramp_last_rc", got[7].r * 8 + got[7].c, 3 * 8 + 5);
        end

        // Back-to-back frames: zeros then 255.
        got.delete();
        send_range(0, 0, 0, W*H-1, 0);
        send_range(0, 255, 0, W*H-1, 0);
        drain();
        chk("b2b_count", got.size(), 16);
        if (got.size() == 16) begin
            chk("b2b_zero", got[7].d, 0);
            chk("b2b_255", got[8].d, 255);
        end

        // Consumer stalls 10 cycles: result held, no pixel accepted.
        rr_mode = 2;
        send_range(2, 0, 0, 36, 0);
        begin
            int t = 0;
            while (!res_valid && t < 100) begin @(posedge clk); #1; t++; end
            chk("hold_valid_timeout", int'(t < 100), 1);
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("hold_res_valid", res_valid, 1);
        chk("hold_pix_ready", pix_ready, 0);
        @(posedge clk); #1;
        rr_mode = 1;
        send_range(2, 0, 37, W*H-1, 20);
        drain();

        // Reset mid-LOAD, then a fresh frame.
        rr_mode = 0;
        send_range(2, 0, 0, 36, 0);
        repeat (5) @(posedge clk);
        #1 rst_b = 1'b0;
        @(negedge clk);
        chk("abort_bCE", det_bCE, 1);
        chk("abort_bOPEn", det_bOPEn, 1);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_pix_ready", pix_ready, 0);
        @(posedge clk); #1 rst_b = 1'b1;
        got.delete();
        send_range(2, 0, 0, W*H-1, 0);
        drain();
        chk("fresh_count", got.size(), 8);
        if (got.size() == 8) chk("fresh_first_rc", got[0].r * 8 + got[0].c, 2 * 8 + 2);

        // Randomized frames with gaps and random back-pressure.
        rr_mode = 1;
        for (int f = 0; f < 4; f++) send_range(2, 0, 0, W*H-1, 30);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
